// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request at a time, a one-entry hold
// buffer for responses that arrive while ID is stalled, and redirect squashing.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [63:0] if_id
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_e;

    localparam if_id_t      IF_ID_BUBBLE  = '{pc: 32'h0, inst: 32'h0};
    localparam logic [31:0] RESET_PC_WORD = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    logic        if_id_valid_q, if_id_valid_d;
    if_id_t      hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;

    logic        fetch_req;
    logic        out_free;

    assign fetch_req   = (state_q == FETCH) && !redirect_valid;
    assign out_free    = !if_id_valid_q || !id_stall;

    // Reset gates the request combinationally so nothing is issued while rst is high.
    assign imem_req    = fetch_req && !rst;
    assign imem_addr   = pc_q;
    assign if_id_valid = if_id_valid_q;
    assign if_id       = if_id_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_d       = if_id_q;
        if_id_valid_d = if_id_valid_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;

        // Consumption by ID; a load below overrides this.
        if (if_id_valid_q && !id_stall) begin
            if_id_valid_d = 1'b0;
        end

        if (redirect_valid) begin
            pc_d          = {redirect_pc[31:2], 2'b00};
            if_id_valid_d = 1'b0;
            hold_d        = IF_ID_BUBBLE;
            hold_valid_d  = 1'b0;
            unique case (state_q)
                FETCH, HOLD: state_d = FETCH;
                WAIT:        state_d = imem_rvalid ? FETCH : DROP;
                DROP:        state_d = DROP;
                default:     state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (fetch_req) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        pc_d = pc_q + 32'd4;
                        if (out_free) begin
                            if_id_d       = '{pc: pc_q, inst: imem_rdata};
                            if_id_valid_d = 1'b1;
                            state_d       = FETCH;
                        end else begin
                            hold_d       = '{pc: pc_q, inst: imem_rdata};
                            hold_valid_d = 1'b1;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!id_stall && hold_valid_q) begin
                        if_id_d       = hold_q;
                        if_id_valid_d = 1'b1;
                        hold_valid_d  = 1'b0;
                        state_d       = FETCH;
                    end
                end
                DROP: begin
                    // The squashed response is swallowed here, never written to if_id.
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC_WORD;
            if_id_q       <= IF_ID_BUBBLE;
            if_id_valid_q <= 1'b0;
            hold_q        <= IF_ID_BUBBLE;
            hold_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_q       <= if_id_d;
            if_id_valid_q <= if_id_valid_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
        end
    end

endmodule
